// File: rtl/lc4_iter_divider.sv
// lc4_iter_divider: multi-cycle unsigned restoring divider for the ALU's
// DIV and MOD operations. One quotient bit is produced per clock, and the
// trial subtraction runs through a 16-bit carry-lookahead adder.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request a division (ignored while busy)
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while iterations are running
//   done         one-cycle pulse when quotient/remainder were just written
//   quotient     registered quotient (0 on divide-by-zero)
//   remainder    registered remainder (0 on divide-by-zero)
//   div_by_zero  registered flag accompanying a divisor==0 result
//
// cla16: 16-bit adder built from four 4-bit lookahead groups, with a
// second lookahead level across the groups.
//   a, b, cin    operands and carry in
//   sum, cout    result and carry out

module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int unsigned k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int unsigned j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

module lc4_iter_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] q_sr;
  logic [WIDTH-1:0] d_reg;
  // Partial remainder held in WIDTH bits: after every iteration it is
  // either Rs - D or a rejected Rs < D, so its top (17th) bit is always 0.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] diff;
  logic             diff_cout;
  logic             accept;
  logic             load;
  logic             last_iter;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign rs = {r_reg, q_sr[WIDTH-1]};

  cla16 u_cla (
    .a    (rs[WIDTH-1:0]),
    .b    (~d_reg),
    .cin  (1'b1),
    .sum  (diff),
    .cout (diff_cout)
  );

  // Carry out of Rs[15:0] + ~D + 1 means Rs[15:0] >= D; a set Rs[16]
  // already exceeds any 16-bit divisor.
  assign accept    = rs[WIDTH] | diff_cout;
  assign r_next    = accept ? diff : rs[WIDTH-1:0];
  assign q_next    = {q_sr[WIDTH-2:0], accept};
  assign load      = start && (state != S_RUN);
  assign last_iter = (state == S_RUN) && (count == CW'(WIDTH - 1));

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_iter) state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sr        <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      q_sr  <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      count <= '0;
    end else if (state == S_RUN) begin
      q_sr  <= q_next;
      r_reg <= r_next;
      count <= count + CW'(1);
      if (last_iter) begin
        if (d_reg == '0) begin
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= q_next;
          remainder   <= r_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lc4_iter_divider.sv
// Self-checking bench for lc4_iter_divider: directed corner cases plus
// randomized operands compared against plain '/' and '%' arithmetic.

module tb_lc4_iter_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  lc4_iter_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request now; it is taken on the next rising edge (E0).
  // Returns 1 ns after E0 with start released.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    check_eq("done_after_start", {31'd0, done}, 32'd0);
  endtask

  // Waits for done (bounded) and checks edges-to-done, busy span, output
  // stability during the run and the expected results.
  task automatic wait_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int unsigned exp_lat);
    int unsigned n = 0;
    int unsigned busy_cnt = 0;
    bit changed = 0;
    logic [15:0] q0 = quotient;
    logic [15:0] r0 = remainder;
    logic [15:0] exp_q = (b == 16'd0) ? 16'd0 : a / b;
    logic [15:0] exp_r = (b == 16'd0) ? 16'd0 : a % b;
    logic        exp_z = (b == 16'd0);
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (busy) busy_cnt++;
      if (quotient !== q0 || remainder !== r0) changed = 1;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_busy_span"}, busy_cnt, exp_lat - 1);
    check_eq({tag, "_hold"}, {31'd0, changed}, 32'd0);
    check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_q"}, {16'd0, quotient}, {16'd0, exp_q});
    check_eq({tag, "_r"}, {16'd0, remainder}, {16'd0, exp_r});
    check_eq({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
  endtask

  // One idle cycle after done: the pulse must be gone and results held.
  task automatic idle_after(input string tag, input logic [15:0] q, input logic [15:0] r);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_width"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_q_hold"}, {16'd0, quotient}, {16'd0, q});
    check_eq({tag, "_r_hold"}, {16'd0, remainder}, {16'd0, r});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_q", {16'd0, quotient}, 32'd0);
    check_eq("rst_r", {16'd0, remainder}, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic
    start_op(16'd100, 16'd7);
    wait_done("basic", 16'd100, 16'd7, 16);
    idle_after("basic", 16'd14, 16'd2);
    repeat (3) @(posedge clk);
    #1;
    check_eq("basic_long_hold_q", {16'd0, quotient}, 32'd14);

    // Extremes
    start_op(16'hFFFF, 16'h0001);
    wait_done("ffff_1", 16'hFFFF, 16'h0001, 16);
    idle_after("ffff_1", 16'hFFFF, 16'h0000);
    start_op(16'hFFFF, 16'hFFFF);
    wait_done("ffff_ffff", 16'hFFFF, 16'hFFFF, 16);
    idle_after("ffff_ffff", 16'h0001, 16'h0000);
    start_op(16'h1234, 16'h8000);
    wait_done("small_big", 16'h1234, 16'h8000, 16);
    idle_after("small_big", 16'h0000, 16'h1234);
    start_op(16'h0000, 16'h0013);
    wait_done("zero_dividend", 16'h0000, 16'h0013, 16);
    idle_after("zero_dividend", 16'h0000, 16'h0000);

    // Divide by zero, then a normal op clears the flag
    start_op(16'h00AB, 16'h0000);
    wait_done("div0", 16'h00AB, 16'h0000, 16);
    idle_after("div0", 16'h0000, 16'h0000);
    start_op(16'd9, 16'd3);
    wait_done("after_div0", 16'd9, 16'd3, 16);
    idle_after("after_div0", 16'd3, 16'd0);

    // Start while busy is ignored; back-to-back start in the done cycle
    start_op(16'd1000, 16'd10);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    start    = 1'b1;
    dividend = 16'd5;
    divisor  = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore_start", 16'd1000, 16'd10, 8);
    start_op(16'd50, 16'd6);
    wait_done("b2b", 16'd50, 16'd6, 16);
    idle_after("b2b", 16'd8, 16'd2);

    // Asynchronous reset in the middle of a run
    start_op(16'd40000, 16'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_q", {16'd0, quotient}, 32'd0);
    check_eq("midrst_r", {16'd0, remainder}, 32'd0);
    begin
      bit saw_done = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (done) saw_done = 1;
      end
      check_eq("midrst_no_done", {31'd0, saw_done}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    start_op(16'd40000, 16'd3);
    wait_done("after_rst", 16'd40000, 16'd3, 16);
    idle_after("after_rst", 16'd13333, 16'd1);

    // Random operands, mixing idle gaps and back-to-back starts
    for (int unsigned i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      bit          b2b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(1, 15));
        1:       b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      if (b == 16'd0) b = 16'd1;
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 3));
      b2b = ($urandom_range(0, 1) == 1);
      start_op(a, b);
      wait_done("rand", a, b, 16);
      if (!b2b) idle_after("rand", a / b, a % b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
